// File: rtl/cleared_dual_port_ram.sv
// Simple dual-port RAM (one write, one read port, one clock) with read-valid strobe,
// optional output register and a clear engine. Define DPRAM_BYPASS_EN for write-first collisions.
module cleared_dual_port_ram #(
  parameter int                WIDTH       = 13,
  parameter int                LENGTH      = 12,
  parameter int                OUT_REG     = 0,
  parameter logic [LENGTH-1:0] CLEAR_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              we,
  input  logic [WIDTH-1:0]  write_addr,
  input  logic [LENGTH-1:0] din,
  input  logic              re,
  input  logic [WIDTH-1:0]  read_addr,
  output logic [LENGTH-1:0] dout,
  output logic              dout_valid,
  output logic              busy
);

  localparam int DEPTH = 2**WIDTH;
  localparam logic [WIDTH:0] CLR_LAST = (WIDTH+1)'(DEPTH - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t            state;
  state_t            state_next;
  logic [WIDTH:0]    clr_addr;
  logic              accept;
  logic              wr_fire;
  logic              rd_fire;
  logic [LENGTH-1:0] rd_word;
  logic [LENGTH-1:0] mem [DEPTH];

  // A clear request in READY pre-empts any same-cycle port access.
  assign accept  = (state == READY) && !clear;
  assign wr_fire = accept && we;
  assign rd_fire = accept && re;
  assign busy    = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (!rst) state <= CLEAR;
    else      state <= state_next;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_addr == CLR_LAST) state_next = READY;
      READY:   if (clear)                state_next = CLEAR;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)                 clr_addr <= '0;
    else if (state == CLEAR)  clr_addr <= clr_addr + 1'b1;
    else if (clear)           clr_addr <= '0;
  end

  // NOTE: the array has no reset; it is initialised by the clear engine instead,
  // and left untouched while rst is held low.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state == CLEAR) mem[clr_addr[WIDTH-1:0]] <= CLEAR_VALUE;
      else if (wr_fire)   mem[write_addr]          <= din;
    end
  end

`ifdef DPRAM_BYPASS_EN
  // Write-first: a same-cycle write to the read address is forwarded.
  always_comb begin
    rd_word = mem[read_addr];
    if (wr_fire && (write_addr == read_addr)) rd_word = din;
  end
`else
  // Read-first: the non-blocking array update leaves the old word visible.
  assign rd_word = mem[read_addr];
`endif

  if (OUT_REG == 0) begin : g_lat1
    always_ff @(posedge clk) begin
      if (!rst) begin
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        dout_valid <= rd_fire;
        if (rd_fire) dout <= rd_word;
      end
    end
  end else begin : g_lat2
    logic [LENGTH-1:0] s1_data;
    logic              s1_valid;

    always_ff @(posedge clk) begin
      if (rd_fire) s1_data <= rd_word;
    end

    // A clear flushes the word in stage 1 instead of letting it complete.
    always_ff @(posedge clk) begin
      if (!rst) begin
        s1_valid   <= 1'b0;
        dout       <= '0;
        dout_valid <= 1'b0;
      end else begin
        s1_valid   <= rd_fire;
        dout_valid <= s1_valid && accept;
        if (s1_valid && accept) dout <= s1_data;
      end
    end
  end

endmodule

// File: tb/tb_cleared_dual_port_ram.sv
// Bench for cleared_dual_port_ram: two instances (latency 1 and latency 2) share stimulus;
// directed table plus hand-written clear/reset sequences.
module tb_cleared_dual_port_ram;

  localparam int          W  = 4;
  localparam int          L  = 12;
  localparam logic [11:0] CV = 12'hABC;

  logic         clk = 1'b0;
  logic         rst, clear, we, re;
  logic [W-1:0] write_addr, read_addr;
  logic [L-1:0] din;
  logic [L-1:0] d1_dout, d2_dout;
  logic         d1_valid, d2_valid, d1_busy, d2_busy;

  int errors = 0;
  int checks = 0;

  cleared_dual_port_ram #(.WIDTH(W), .LENGTH(L), .OUT_REG(0), .CLEAR_VALUE(CV)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .we(we), .write_addr(write_addr), .din(din),
    .re(re), .read_addr(read_addr), .dout(d1_dout), .dout_valid(d1_valid), .busy(d1_busy)
  );

  cleared_dual_port_ram #(.WIDTH(W), .LENGTH(L), .OUT_REG(1), .CLEAR_VALUE(CV)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .we(we), .write_addr(write_addr), .din(din),
    .re(re), .read_addr(read_addr), .dout(d2_dout), .dout_valid(d2_valid), .busy(d2_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         we;
    logic [W-1:0] wa;
    logic [L-1:0] d;
    logic         re;
    logic [W-1:0] ra;
    logic         ev;
    logic [L-1:0] ed;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; we = 1'b0; re = 1'b0;
    write_addr = '0; read_addr = '0; din = '0;
  endtask

  task automatic count_busy(input string name, input bit poke_clear, output int n);
    int bad;
    n = 0;
    bad = 0;
    while (d1_busy && n < 100) begin
      clear = poke_clear && (n == 8);
      tick();
      n++;
      if (d1_valid || d2_valid) bad++;
    end
    clear = 1'b0;
    check({name, "_len"}, n, 16);
    check({name, "_d2_busy"}, d2_busy, 1'b0);
    check({name, "_no_valid"}, bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n;
    logic        prev_v;
    logic [11:0] prev_d;
    logic [11:0] coll_exp;

`ifdef DPRAM_BYPASS_EN
    coll_exp = 12'd7;
`else
    coll_exp = 12'd1;
`endif
    vecs[0] = '{1'b1, 4'd5, 12'd10, 1'b0, 4'd0, 1'b0, CV};
    vecs[1] = '{1'b0, 4'd0, 12'd0,  1'b1, 4'd5, 1'b1, 12'd10};
    vecs[2] = '{1'b0, 4'd0, 12'd0,  1'b0, 4'd0, 1'b0, 12'd10};
    vecs[3] = '{1'b1, 4'd3, 12'd1,  1'b0, 4'd0, 1'b0, 12'd10};
    vecs[4] = '{1'b1, 4'd3, 12'd7,  1'b1, 4'd3, 1'b1, coll_exp};
    vecs[5] = '{1'b0, 4'd0, 12'd0,  1'b1, 4'd3, 1'b1, 12'd7};
    for (int i = 0; i < 8; i++) begin
      vecs[6+i]  = '{1'b1, 4'(i), 12'(i*3), 1'b0, 4'd0,  1'b0, 12'd7};
      vecs[14+i] = '{1'b0, 4'd0,  12'd0,    1'b1, 4'(i), 1'b1, 12'(i*3)};
    end

    // Reset pulse, then the initial clear
    idle();
    rst = 1'b0;
    tick();
    check("rst_busy1",  d1_busy,  1'b1);
    check("rst_busy2",  d2_busy,  1'b1);
    check("rst_dout1",  d1_dout,  12'd0);
    check("rst_valid1", d1_valid, 1'b0);
    check("rst_dout2",  d2_dout,  12'd0);
    check("rst_valid2", d2_valid, 1'b0);
    rst = 1'b1;
    re = 1'b1;
    we = 1'b1;
    count_busy("init_clear", 1'b0, n);

    // Every address reads CLEAR_VALUE
    idle();
    for (int i = 0; i < 16; i++) begin
      re = 1'b1;
      read_addr = 4'(i);
      tick();
      check($sformatf("clr_rd%0d_v1", i), d1_valid, 1'b1);
      check($sformatf("clr_rd%0d_d1", i), d1_dout, CV);
      check($sformatf("clr_rd%0d_v2", i), d2_valid, i > 0);
      check($sformatf("clr_rd%0d_d2", i), d2_dout, (i > 0) ? CV : 12'd0);
    end

    // Directed table: latency-2 instance trails the latency-1 expectation by one cycle
    prev_v = 1'b1;
    prev_d = CV;
    for (int i = 0; i < 22; i++) begin
      we = vecs[i].we; write_addr = vecs[i].wa; din = vecs[i].d;
      re = vecs[i].re; read_addr = vecs[i].ra; clear = 1'b0;
      tick();
      check($sformatf("vec%0d_v1", i), d1_valid, vecs[i].ev);
      check($sformatf("vec%0d_d1", i), d1_dout,  vecs[i].ed);
      check($sformatf("vec%0d_v2", i), d2_valid, prev_v);
      check($sformatf("vec%0d_d2", i), d2_dout,  prev_d);
      prev_v = vecs[i].ev;
      prev_d = vecs[i].ed;
    end

    // Clear mid-traffic: read in flight, then clear with a write and a read
    idle();
    re = 1'b1; read_addr = 4'd4;
    tick();
    check("pre_clr_v1", d1_valid, 1'b1);
    check("pre_clr_d1", d1_dout,  12'd12);
    check("pre_clr_v2", d2_valid, 1'b1);
    check("pre_clr_d2", d2_dout,  12'd21);
    clear = 1'b1; we = 1'b1; write_addr = 4'd2; din = 12'd9; re = 1'b1; read_addr = 4'd3;
    tick();
    check("clr_edge_v1",   d1_valid, 1'b0);
    check("clr_edge_d1",   d1_dout,  12'd12);
    check("clr_edge_v2",   d2_valid, 1'b0);
    check("clr_edge_d2",   d2_dout,  12'd21);
    check("clr_edge_busy", d1_busy,  1'b1);
    clear = 1'b0; we = 1'b1; write_addr = 4'd6; din = 12'd5; re = 1'b1; read_addr = 4'd6;
    count_busy("mid_clear", 1'b1, n);
    idle();
    re = 1'b1; read_addr = 4'd2;
    tick();
    check("after_clr_a2_v", d1_valid, 1'b1);
    check("after_clr_a2_d", d1_dout,  CV);
    read_addr = 4'd6;
    tick();
    check("after_clr_a6_d", d1_dout, CV);
    read_addr = 4'd3;
    tick();
    check("after_clr_a3_d", d1_dout, CV);

    // Reset during clear cycle 6 of 16 restarts the sweep
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("rmc_busy_start", d1_busy, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    tick();
    check("rmc_busy_rst", d1_busy,  1'b1);
    check("rmc_dout_rst", d1_dout,  12'd0);
    check("rmc_valid",    d1_valid, 1'b0);
    rst = 1'b1;
    count_busy("rst_mid_clear", 1'b0, n);
    re = 1'b1; read_addr = 4'd5;
    tick();
    check("rmc_rd5_v1", d1_valid, 1'b1);
    check("rmc_rd5_d1", d1_dout,  CV);
    check("rmc_rd5_v2", d2_valid, 1'b0);
    idle();
    tick();
    check("rmc_rd5_v2b", d2_valid, 1'b1);
    check("rmc_rd5_d2b", d2_dout,  CV);
    check("rmc_idle_v1", d1_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
